// File: rtl/game_timer_ctrl.sv
// On-screen game timer: 1 s prescaler, 3-digit BCD seconds counter under a
// start/pause/clear FSM, with digits latched at frame start to avoid tearing.
module game_timer_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       frame_start,
  output logic [3:0] time_1s,
  output logic [3:0] time_10s,
  output logic [3:0] time_100s,
  output logic       running,
  output logic       done,
  output logic       sec_tick
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] presc, presc_n;
  logic [3:0]       d1, d10, d100;
  logic [3:0]       n1, n10, n100;
  logic             tick, at_max;

  assign tick   = (state == RUN) && (presc == LAST);
  assign at_max = (d100 == 4'd9) && (d10 == 4'd9) && (d1 == 4'd9);

  always_comb begin
    state_n = state;
    presc_n = presc;
    n1      = d1;
    n10     = d10;
    n100    = d100;
    if (clear) begin
      state_n = IDLE;
      presc_n = '0;
      n1      = '0;
      n10     = '0;
      n100    = '0;
    end else begin
      unique case (state)
        IDLE:  if (start) state_n = RUN;
        PAUSE: if (start) state_n = RUN;
        RUN: begin
          presc_n = tick ? '0 : presc + 1'b1;
          if (tick && at_max) state_n = DONE;
          else if (pause)     state_n = PAUSE;
          // 999 saturates: the last tick only moves the FSM to DONE
          if (tick && !at_max) begin
            if (d1 != 4'd9) begin
              n1 = d1 + 4'd1;
            end else begin
              n1 = '0;
              if (d10 != 4'd9) begin
                n10 = d10 + 4'd1;
              end else begin
                n10  = '0;
                n100 = d100 + 4'd1;
              end
            end
          end
        end
        DONE: ;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      presc     <= '0;
      d1        <= '0;
      d10       <= '0;
      d100      <= '0;
      time_1s   <= '0;
      time_10s  <= '0;
      time_100s <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      sec_tick  <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      d1       <= n1;
      d10      <= n10;
      d100     <= n100;
      running  <= (state_n == RUN);
      done     <= (state_n == DONE);
      sec_tick <= tick && !clear;
      if (frame_start) begin
        time_1s   <= n1;
        time_10s  <= n10;
        time_100s <= n100;
      end
    end
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with a 4-cycle second.
// Continuous monitor guards digit range and frame-synchronous updates.
module tb_game_timer_ctrl;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       frame_start = 1'b0;
  logic [3:0] time_1s, time_10s, time_100s;
  logic       running, done, sec_tick;

  int vectors = 0;
  int miscompares = 0;

  logic        mon_en = 1'b0;
  logic [11:0] prev_tv = '0;
  logic        prev_fs = 1'b0;
  logic        prev_rst = 1'b1;
  logic [11:0] tv;

  assign tv = {time_100s, time_10s, time_1s};

  game_timer_ctrl #(
    .TICK_DIV(4),
    .CNT_W   (3)
  ) dut (
    .vga_clk    (clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .frame_start(frame_start),
    .time_1s    (time_1s),
    .time_10s   (time_10s),
    .time_100s  (time_100s),
    .running    (running),
    .done       (done),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (time_1s > 9 || time_10s > 9 || time_100s > 9) begin
        miscompares++;
        $display("FAIL digit_range: got %h required each digit <= 9", tv);
      end
      vectors++;
      if (tv !== prev_tv && !prev_fs && !prev_rst) begin
        miscompares++;
        $display("FAIL shadow_hold: got %h required %h (no frame_start)",
                 tv, prev_tv);
      end
    end
    prev_tv  = tv;
    prev_fs  = frame_start;
    prev_rst = sys_rst;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    frame_start = 1'b0;
    cyc(2);
    sys_rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    vectors++;
    if ({tv, running, done, sec_tick} !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_state: got time=%h r=%b d=%b t=%b required 0",
               tv, running, done, sec_tick);
    end
  endtask

  task automatic test_count();
    int n = 0;
    do_reset();
    pulse_start();
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL run_after_start: got %b required 1", running);
    end
    repeat (40) begin
      cyc(1);
      if (sec_tick) n++;
    end
    vectors++;
    if (n != 10) begin
      miscompares++;
      $display("FAIL tick_count40: got %0d required 10", n);
    end
    vectors++;
    if (tv !== 12'h000) begin
      miscompares++;
      $display("FAIL no_fs_hold: got %h required 000", tv);
    end
    pulse_fs();
    vectors++;
    if (tv !== 12'h010) begin
      miscompares++;
      $display("FAIL count40: got %h required 010", tv);
    end
  endtask

  task automatic test_pause_resume();
    int n = 0;
    do_reset();
    pulse_start();
    cyc(5);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    vectors++;
    if (running !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_running: got %b required 0", running);
    end
    repeat (100) begin
      cyc(1);
      if (sec_tick) n++;
    end
    vectors++;
    if (n != 0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_hold: got ticks=%0d r=%b required 0 0", n, running);
    end
    pulse_start();
    vectors++;
    if (running !== 1'b1 || sec_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL resume: got r=%b t=%b required 1 0", running, sec_tick);
    end
    cyc(1);
    vectors++;
    if (sec_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL resume_early: got %b required 0", sec_tick);
    end
    cyc(1);
    vectors++;
    if (sec_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL resume_tick: got %b required 1", sec_tick);
    end
    pulse_fs();
    vectors++;
    if (tv !== 12'h002) begin
      miscompares++;
      $display("FAIL pause_count: got %h required 002", tv);
    end
    pause = 1'b1;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    pause = 1'b0;
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL start_pause_in_pause: got %b required 1", running);
    end
  endtask

  task automatic test_done();
    int n = 0;
    do_reset();
    pulse_start();
    cyc(3992);
    pulse_fs();
    vectors++;
    if (tv !== 12'h998) begin
      miscompares++;
      $display("FAIL reach_998: got %h required 998", tv);
    end
    cyc(3);
    vectors++;
    if (sec_tick !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_999: got t=%b d=%b required 1 0", sec_tick, done);
    end
    cyc(4);
    vectors++;
    if (sec_tick !== 1'b1 || done !== 1'b1 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL enter_done: got t=%b d=%b r=%b required 1 1 0",
               sec_tick, done, running);
    end
    pulse_fs();
    vectors++;
    if (tv !== 12'h999) begin
      miscompares++;
      $display("FAIL done_value: got %h required 999", tv);
    end
    repeat (40) begin
      cyc(1);
      if (sec_tick) n++;
    end
    pulse_start();
    pulse_fs();
    vectors++;
    if (n != 0 || tv !== 12'h999 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_hold: got ticks=%0d time=%h d=%b required 0 999 1",
               n, tv, done);
    end
  endtask

  task automatic test_clear();
    do_reset();
    pulse_start();
    cyc(228);
    pulse_fs();
    vectors++;
    if (tv !== 12'h057) begin
      miscompares++;
      $display("FAIL reach_057: got %h required 057", tv);
    end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(10);
    vectors++;
    if (tv !== 12'h057 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_hold: got %h r=%b required 057 0", tv, running);
    end
    pulse_fs();
    vectors++;
    if (tv !== 12'h000) begin
      miscompares++;
      $display("FAIL clear_shown: got %h required 000", tv);
    end
    pulse_start();
    cyc(3);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    vectors++;
    if (sec_tick !== 1'b0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_tick: got t=%b r=%b required 0 0", sec_tick, running);
    end
    pulse_fs();
    vectors++;
    if (tv !== 12'h000) begin
      miscompares++;
      $display("FAIL clear_tick_val: got %h required 000", tv);
    end
  endtask

  task automatic test_sys_rst();
    do_reset();
    pulse_start();
    cyc(40);
    pulse_fs();
    vectors++;
    if (tv !== 12'h010) begin
      miscompares++;
      $display("FAIL pre_rst: got %h required 010", tv);
    end
    cyc(2);
    sys_rst = 1'b1;
    frame_start = 1'b1;
    cyc(1);
    sys_rst = 1'b0;
    frame_start = 1'b0;
    vectors++;
    if ({tv, running, done, sec_tick} !== 15'h0) begin
      miscompares++;
      $display("FAIL mid_rst: got time=%h r=%b d=%b t=%b required 0",
               tv, running, done, sec_tick);
    end
    pulse_start();
    start = 1'b1;
    pause = 1'b1;
    clear = 1'b1;
    cyc(1);
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    vectors++;
    if (running !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL all_three: got r=%b d=%b required 0 0", running, done);
    end
  endtask

  task automatic test_carry();
    do_reset();
    pulse_start();
    cyc(396);
    cyc(3);
    pulse_fs();
    vectors++;
    if (tv !== 12'h100 || sec_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL carry_100: got %h t=%b required 100 1", tv, sec_tick);
    end
    cyc(36);
    cyc(3);
    pulse_fs();
    vectors++;
    if (tv !== 12'h110) begin
      miscompares++;
      $display("FAIL carry_110: got %h required 110", tv);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause_resume();
    test_done();
    test_clear();
    test_sys_rst();
    test_carry();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
